// File: rtl/pm32_pkg.sv
// Shared types for the pm32 multiplier family: sequencer states, operand widths,
// and the packed operand-pair record carried by the input buffer.
package pm32_pkg;

    localparam int OPER_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        ERR
    } state_t;

    typedef struct packed {
        logic [OPER_W-1:0] a;
        logic [OPER_W-1:0] b;
        logic              last;
    } oper_t;

endpackage

// File: rtl/pm32_dot_buf.sv
// One-entry operand register; zero-latency accept into the slot, holds until popped.
// Backpressure: ready only while empty and enabled; a push wins over a pop in the same cycle.
module pm32_dot_buf
    import pm32_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_vld,
    input  logic  i_en,
    output logic  o_rdy,
    input  oper_t i_dat,
    input  logic  i_pop,
    output logic  o_full,
    output oper_t o_dat
);

    logic  r_full;
    oper_t r_dat;
    logic  w_push;

    assign o_rdy  = !r_full && i_en;
    assign w_push = i_vld && o_rdy;
    assign o_full = r_full;
    assign o_dat  = r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_dat  <= '0;
        end else begin
            if (w_push) begin
                r_full <= 1'b1;
                r_dat  <= i_dat;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pm32_dot_seq.sv
// Sequences signed operand pairs through the pm32 multiplier and accumulates a dot product.
// Pair throughput is multiplier latency + 3 cycles; result is held on res_* until res_ready.
module pm32_dot_seq
    import pm32_pkg::*;
#(
    parameter int ACC_W   = 72,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPER_W-1:0] in_a,
    input  logic [OPER_W-1:0] in_b,
    input  logic              in_last,
    output logic              mul_start,
    output logic [OPER_W-1:0] mul_mc,
    output logic [OPER_W-1:0] mul_mp,
    input  logic [PROD_W-1:0] mul_p,
    input  logic              mul_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_acc,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              res_ovf,
    output logic              err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    oper_t             w_in_dat;
    oper_t             w_buf_dat;
    logic              w_buf_full;
    logic              w_pop;
    logic              w_take;
    logic              w_clear;
    logic              w_wd_exp;
    logic              w_add_ovf;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_sum;
    logic [OPER_W-1:0] r_mc;
    logic [OPER_W-1:0] r_mp;
    logic              r_last;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [WD_W-1:0]   r_wd;

    assign w_in_dat = {in_a, in_b, in_last};

    pm32_dot_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (in_valid),
        .i_en   (r_state != ERR),
        .o_rdy  (in_ready),
        .i_dat  (w_in_dat),
        .i_pop  (w_pop),
        .o_full (w_buf_full),
        .o_dat  (w_buf_dat)
    );

    // Two's-complement add; overflow when both addends share a sign the sum lacks.
    assign w_prod_ext = ACC_W'($signed(mul_p));
    assign w_sum      = r_acc + w_prod_ext;
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_wd_exp   = (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_take    = 1'b0;
        w_clear   = 1'b0;
        mul_start = 1'b0;
        res_valid = 1'b0;
        err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_buf_full) begin
                    w_pop  = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    w_take = 1'b1;
                    w_next = r_last ? OUT : IDLE;
                end else if (w_wd_exp) begin
                    w_next = ERR;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_clear = 1'b1;
                    w_next  = IDLE;
                end
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mc   <= '0;
            r_mp   <= '0;
            r_last <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_wd   <= '0;
        end else begin
            if (w_pop) begin
                r_mc   <= w_buf_dat.a;
                r_mp   <= w_buf_dat.b;
                r_last <= w_buf_dat.last;
            end
            // mul_done may still be high from the previous product during ISSUE.
            if (r_state == ISSUE) begin
                r_wd <= '0;
            end else if (r_state == WAIT && !mul_done) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_take) begin
                r_acc <= w_sum;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_add_ovf) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign mul_mc  = r_mc;
    assign mul_mp  = r_mp;
    assign res_acc = r_acc;
    assign res_cnt = r_cnt;
    assign res_ovf = r_ovf;

endmodule

// File: tb/tb_pm32_dot_seq.sv
// Bench for pm32_dot_seq: behavioural pm32 model plus an arithmetic dot-product reference.
module tb_pm32_dot_seq;

    localparam int ACC_W   = 72;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_a = '0;
    logic [31:0]       in_b = '0;
    logic              in_last = 1'b0;
    logic              mul_start;
    logic [31:0]       mul_mc;
    logic [31:0]       mul_mp;
    logic [63:0]       mul_p = '0;
    logic              mul_done = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res_acc;
    logic [CNT_W-1:0]  res_cnt;
    logic              res_ovf;
    logic              err;

    pm32_dot_seq #(
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_start (mul_start),
        .mul_mc    (mul_mc),
        .mul_mp    (mul_mp),
        .mul_p     (mul_p),
        .mul_done  (mul_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_acc   (res_acc),
        .res_cnt   (res_cnt),
        .res_ovf   (res_ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // pm32 stand-in: done level stays high until the next start, product after a random latency.
    bit hang    = 1'b0;
    int lat_fix = 0;
    int rem     = 0;
    bit busy    = 1'b0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy     = 1'b0;
            mul_done = 1'b0;
            mul_p    = '0;
        end else if (mul_start) begin
            busy = 1'b1;
            rem  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 5));
        end else if (busy) begin
            mul_done = 1'b0;
            rem--;
            if (rem == 0 && !hang) begin
                busy     = 1'b0;
                mul_done = 1'b1;
                mul_p    = longint'($signed(mul_mc)) * longint'($signed(mul_mp));
            end
        end
    end

    logic signed [127:0] m_acc;
    int                  m_cnt;
    bit                  m_ovf;
    logic signed [127:0] acc_max;
    logic signed [127:0] acc_min;
    logic signed [127:0] acc_mod;

    task automatic model_clear();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input logic [31:0] a, input logic [31:0] b);
        logic signed [127:0] p;
        logic signed [127:0] s;
        p = 128'(longint'($signed(a)) * longint'($signed(b)));
        s = m_acc + p;
        if (s > acc_max) begin
            m_ovf = 1'b1;
            s     = s - acc_mod;
        end else if (s < acc_min) begin
            m_ovf = 1'b1;
            s     = s + acc_mod;
        end
        m_acc = s;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        push(a, b, last);
        model_add(a, b);
    endtask

    task automatic get_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, res_valid, 1);
        check({tag, "_acc"}, res_acc, m_acc[ACC_W-1:0]);
        check({tag, "_cnt"}, res_cnt, m_cnt);
        check({tag, "_ovf"}, res_ovf, m_ovf);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_vld_drop"}, res_valid, 0);
        model_clear();
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!mul_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mul_start) check({tag, "_start"}, mul_start, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, mul_start, 0);
        check({tag, "_mc"}, mul_mc, 0);
        check({tag, "_mp"}, mul_mp, 0);
        check({tag, "_rvld"}, res_valid, 0);
        check({tag, "_acc"}, res_acc, 0);
        check({tag, "_cnt"}, res_cnt, 0);
        check({tag, "_ovf"}, res_ovf, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_inrdy"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL tb_timeout elapsed=%0t limit=500000", $time);
        $fatal(1);
    end

    initial begin
        logic [ACC_W-1:0] snap_acc;
        logic [31:0]      ra;
        logic [31:0]      rb;
        int               len;
        int               starts;

        acc_mod = 128'sd1 <<< ACC_W;
        acc_max = (128'sd1 <<< (ACC_W - 1)) - 1;
        acc_min = -(128'sd1 <<< (ACC_W - 1));
        model_clear();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        send(32'd3, 32'd4, 1'b0);
        send(-32'sd2, 32'd5, 1'b1);
        get_result("small");
        check("small_const", res_acc, 0);

        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        check("maxpos_model", m_acc[ACC_W-1:0], 72'h3FFF_FFFF_0000_0001);
        get_result("maxpos");

        send(32'h8000_0000, 32'h8000_0000, 1'b1);
        check("minneg_model", m_acc[ACC_W-1:0], 72'h4000_0000_0000_0000);
        get_result("minneg");

        for (int v = 0; v < 6; v++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                rb = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
                send(ra, rb, i == len - 1);
            end
            get_result("rand");
        end

        // 512 products of 2^62 reach 2^71 and wrap the 72-bit accumulator.
        for (int i = 0; i < 512; i++) begin
            send(32'h8000_0000, 32'h8000_0000, i == 511);
        end
        check("ovf_model", m_ovf, 1);
        get_result("ovf");
        send(32'd1, 32'd1, 1'b1);
        get_result("ovf_clear");

        send(32'd5, 32'd6, 1'b1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("hold_vld0", res_valid, 1);
        snap_acc = m_acc[ACC_W-1:0];
        check("hold_inrdy0", in_ready, 1);
        in_a     = 32'd7;
        in_b     = 32'd8;
        in_last  = 1'b1;
        in_valid = 1'b1;
        starts   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (mul_start) starts++;
            check("hold_vld", res_valid, 1);
            check("hold_acc", res_acc, snap_acc);
            check("hold_cnt", res_cnt, 1);
        end
        check("hold_inrdy", in_ready, 0);
        check("hold_starts", starts, 0);
        get_result("hold");
        model_add(32'd7, 32'd8);
        get_result("buffered");

        hang = 1'b1;
        push(32'd2, 32'd3, 1'b1);
        wait_start("tmo");
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) check("tmo_err_early", err, 0);
            if (k == TIMEOUT + 1) check("tmo_err", err, 1);
        end
        check("tmo_inrdy", in_ready, 0);
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        starts   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mul_start) starts++;
        end
        in_valid = 1'b0;
        check("tmo_starts", starts, 0);
        check("tmo_err_sticky", err, 1);
        check("tmo_inrdy_sticky", in_ready, 0);
        hang = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("tmo_reset");

        lat_fix = 6;
        push(32'd4, 32'd4, 1'b0);
        push(32'd9, 32'd9, 1'b1);
        begin
            int n;
            n = 0;
            while (res_acc == 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("wrst_partial", res_acc, 16);
        wait_start("wrst");
        @(negedge clk);
        check("wrst_mc", mul_mc, 9);
        #1 rst = 1'b1;
        #1 check_zero("wrst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("wrst_next");
        lat_fix = 0;
        model_clear();
        send(32'd1, 32'd1, 1'b1);
        get_result("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
